// File: rtl/fetch_sequencer.sv
// Fetch sequencer: one-outstanding imem requester with a small
// instruction/PC buffer and execute-redirect flush handling.
module fetch_sequencer #(
  parameter int DEPTH      = 2,
  parameter int RESET_WAIT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_en,
  output logic [1:0]  PC_select,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_kind,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        fault
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = $clog2(RESET_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [31:0]   pend_q, pend_d;
  logic          fault_q, fault_d;

  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   buf_pc_q   [DEPTH];
  logic [31:0]   buf_data_q [DEPTH];

  logic redir;
  logic hs;
  logic push;
  logic pop;

  assign redir = redirect_valid &&
                 (redirect_kind == 2'b01 ||
                  redirect_kind == 2'b10);

  assign imem_req_addr = pc;
  assign instr_valid   = (cnt_q != '0);
  assign instr_data    = buf_data_q[rd_q];
  assign instr_pc      = buf_pc_q[rd_q];
  assign fault         = fault_q;
  assign pop           = instr_valid && instr_ready && !redir;

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    pend_d         = pend_q;
    fault_d        = fault_q;
    imem_req_valid = 1'b0;
    pc_en          = 1'b0;
    PC_select      = 2'b00;
    push           = 1'b0;
    hs             = 1'b0;
    if (redir) begin
      pc_en     = 1'b1;
      PC_select = redirect_kind;
      fault_d   = 1'b0;
      // An in-flight response must still be swallowed unless it lands now
      unique case (state_q)
        S_WAIT, S_DRAIN:
          state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
        default:
          state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (wait_q == '0) state_d = S_REQ;
          else wait_d = wait_q - WW'(1);
        end
        S_REQ: begin
          imem_req_valid = (cnt_q < CW'(DEPTH));
          hs = imem_req_valid && imem_req_ready;
          if (hs) begin
            pend_d  = pc;
            pc_en   = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (imem_rsp_err) begin
              fault_d = 1'b1;
              state_d = S_FAULT;
            end else begin
              push    = 1'b1;
              state_d = S_REQ;
            end
          end
        end
        S_DRAIN: begin
          if (imem_rsp_valid) state_d = S_REQ;
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wait_q  <= WW'(RESET_WAIT);
      pend_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (redir) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      if (push && !pop)
        cnt_q <= cnt_q + CW'(1);
      else if (pop && !push)
        cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      buf_pc_q[wr_q]   <= pend_q;
      buf_data_q[wr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the fetch datapath, which holds the PC register, the pc+4 / pc+offset / jalr-target mux and the PC_select input.
- Sequences instruction-memory requests over a valid/ready handshake and allows one outstanding request.
- Buffers returned instructions with their PCs in a small FIFO for decode.
- On a redirect from execute: drives PC_select, flushes buffered instructions and drops any in-flight response.

Parameters:
- DEPTH, 2: instruction buffer entries, power of two, at least 2.
- RESET_WAIT, 1: idle cycles after reset deassertion before the first request, at least 1.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- pc  input  32  current PC from the fetch datapath
- pc_en  output  1  load enable for the datapath PC register
- PC_select  output  2  00 = pc+4, 01 = pc+offset, 10 = jalr target
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts the request
- imem_req_addr  output  32  fetch address; always equals pc
- imem_rsp_valid  input  1  response valid, one cycle per accepted request
- imem_rsp_data  input  32  instruction word
- imem_rsp_err  input  1  access fault for this response
- redirect_valid  input  1  control transfer resolved in execute
- redirect_kind  input  2  01 = branch/jal, 10 = jalr; 00 and 11 are illegal and treated as no redirect
- instr_valid  output  1  buffer head valid
- instr_ready  input  1  decode consumes the head
- instr_data  output  32  head instruction
- instr_pc  output  32  head PC
- fault  output  1  sticky fetch-fault flag

Behaviour:
- Reset (asynchronous, active-low) values: state=IDLE; wait counter=RESET_WAIT; FIFO empty; pending_addr=0; fault=0; instr_valid=0; imem_req_valid=0; pc_en=0; PC_select=00.
- States:
  - IDLE: counts down RESET_WAIT cycles, then goes to REQ.
  - REQ: imem_req_valid=1 when occupancy+1 <= DEPTH and redirect_valid=0. Handshake (valid & ready): latch pending_addr=pc, pulse pc_en with PC_select=00, go to WAIT. The handshake is zero-latency; the PC advances the following edge.
  - WAIT: on imem_rsp_valid with err=0, push {pending_addr, data} and go to REQ. With err=1, push nothing, set fault, go to FAULT.
  - DRAIN: discards the next imem_rsp_valid, including errored ones, then goes to REQ.
  - FAULT: no requests; instr_valid may still drain existing entries.
- Redirect (redirect_valid=1 with a legal kind), checked every state, highest priority:
  - pc_en=1 and PC_select=redirect_kind that same cycle.
  - FIFO flushed the next edge; a same-cycle decode pop is a no-op.
  - imem_req_valid masked that cycle; the memory must tolerate valid withdrawal.
  - Next state: from WAIT, DRAIN if no response arrives this cycle. A response arriving in the redirect cycle is discarded and the next state is REQ. From DRAIN, stays DRAIN. From REQ/FAULT/IDLE, goes to REQ. fault clears.
- In IDLE the redirect still loads the PC and exits the wait early.
- pc_en is asserted only for the handshake or the redirect; both never fire in one cycle.
- FIFO rules:
  - Push and pop in the same cycle are allowed, including when full.
  - Pointers wrap modulo DEPTH.
  - instr_valid = (count != 0).
  - The occupancy check (count + in-flight) prevents overflow, so no response is ever dropped for lack of space.
- A response outside WAIT/DRAIN is a protocol error and is ignored.
- Reset mid-transaction returns everything to its reset values; a late response after reset is ignored (state IDLE).

Test Plan:
- Reset, then req_ready=1 and 1-cycle responses 0x00000013, 0x00100093, with decode always ready: first req_valid 2 cycles after reset release; addr 0x0, then 0x4. Decode sees pc 0x0 then 0x4; pc_en pulses with PC_select=00.
- Hold instr_ready=0 with DEPTH=2: exactly 2 instructions buffered (PCs 0x0, 0x4); req_valid stays 0 while count=2. Release ready: fetch resumes at 0x8, no instruction lost or duplicated.
- Redirect kind=01 in WAIT (request 0x8 outstanding), response arrives 2 cycles later: pc_en=1, PC_select=01 that cycle. FIFO empties next cycle; response for 0x8 discarded; next request uses the redirected pc with no stale instruction delivered.
- Redirect kind=10 in the same cycle as imem_rsp_valid: response discarded, state REQ, PC_select=10. Redirect kind=00: ignored, sequential fetch continues.
- imem_rsp_err=1 for address 0xC: fault=1 next cycle; no further requests; earlier entries drain. Redirect kind=01 then clears fault and fetch restarts.
- Reset asserted while in WAIT and during a full FIFO: all outputs return to reset values immediately; a response arriving after release is ignored.
